panel_bus_arbiter: RTL and testbench

Shares the single LED-panel write bus (ctrl_en/ctrl_wr/ctrl_addr/ctrl_wdat) between two write requesters: port A (network-side pixel writer) and port B (local pattern/overlay source). An optional third internal requester, a frame-clear engine, is compiled in by macro. The block sits between the requesters and the panel framebuffer memories, and owns arbitration, burst locking and lock timeout.

---
 rtl/panel_bus_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_panel_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/panel_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : panel_bus_arbiter                                             |
// | Desc     : Shares the LED-panel write bus between requester A (network   |
// |            pixel writer) and requester B (local pattern/overlay source)  |
// |            with round-robin arbitration, burst locking and a lock        |
// |            timeout. Define PANEL_ARB_CLEAR_EN to add a frame-clear       |
// |            engine as a third requester (clear_start / clear_busy ports). |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module panel_bus_arbiter #(
  parameter int unsigned CLEAR_WORDS  = 4096,
  parameter logic [23:0] CLEAR_VALUE  = 24'h000000,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic        a_lock,
  input  logic [8:0]  a_en,
  input  logic [15:0] a_addr,
  input  logic [23:0] a_wdat,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic        b_lock,
  input  logic [8:0]  b_en,
  input  logic [15:0] b_addr,
  input  logic [23:0] b_wdat,
`ifdef PANEL_ARB_CLEAR_EN
  input  logic        clear_start,
  output logic        clear_busy,
`endif
  output logic [8:0]  ctrl_en,
  output logic [3:0]  ctrl_wr,
  output logic [15:0] ctrl_addr,
  output logic [23:0] ctrl_wdat,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  // Counter widths only need to reach the last value (limit - 1).
  localparam int unsigned TO_W  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int unsigned CLR_W = (CLEAR_WORDS > 1) ? $clog2(CLEAR_WORDS) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_WORDS - 1);

  // State encoding doubles as the grant code (0 none, 1 A, 2 B, 3 clear).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2,
    CLEAR = 2'd3
  } state_t;

  // Reset value of the last-owner pointer makes A the first choice.
`ifdef PANEL_ARB_CLEAR_EN
  localparam state_t RESET_LAST = CLEAR;
`else
  localparam state_t RESET_LAST = OWN_B;
`endif

  state_t             state_q, state_d;
  state_t             last_q, last_d;
  state_t             winner;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [CLR_W-1:0]   clr_addr_q, clr_addr_d;
  logic               a_ready_q, a_ready_d;
  logic               b_ready_q, b_ready_d;
  logic [1:0]         grant_q, grant_d;
  logic               terr_q, terr_d;
  logic [8:0]         ctrl_en_q, ctrl_en_d;
  logic [3:0]         ctrl_wr_q, ctrl_wr_d;
  logic [15:0]        ctrl_addr_q, ctrl_addr_d;
  logic [23:0]        ctrl_wdat_q, ctrl_wdat_d;
  logic               clr_req;

  // The beat fields of whichever port currently owns the bus.
  logic               own_valid;
  logic               own_lock;
  logic [8:0]         own_en;
  logic [15:0]        own_addr;
  logic [23:0]        own_wdat;

  assign own_valid = (state_q == OWN_A) ? a_valid : b_valid;
  assign own_lock  = (state_q == OWN_A) ? a_lock  : b_lock;
  assign own_en    = (state_q == OWN_A) ? a_en    : b_en;
  assign own_addr  = (state_q == OWN_A) ? a_addr  : b_addr;
  assign own_wdat  = (state_q == OWN_A) ? a_wdat  : b_wdat;

  // Round-robin pick: the requester after the last owner has first claim.
  always_comb begin
    winner = IDLE;
    case (last_q)
      OWN_A: begin
        if (b_valid)      winner = OWN_B;
        else if (clr_req) winner = CLEAR;
        else if (a_valid) winner = OWN_A;
      end
      OWN_B: begin
        if (clr_req)      winner = CLEAR;
        else if (a_valid) winner = OWN_A;
        else if (b_valid) winner = OWN_B;
      end
      default: begin
        if (a_valid)      winner = OWN_A;
        else if (b_valid) winner = OWN_B;
        else if (clr_req) winner = CLEAR;
      end
    endcase
  end

  // Next-state, burst/timeout handling and the registered write bus.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    to_cnt_d    = to_cnt_q;
    clr_addr_d  = clr_addr_q;
    terr_d      = 1'b0;
    ctrl_en_d   = 9'h000;
    ctrl_wr_d   = 4'h0;
    ctrl_addr_d = ctrl_addr_q;
    ctrl_wdat_d = ctrl_wdat_q;
    case (state_q)
      IDLE: begin
        state_d = winner;
        if (winner != IDLE) begin
          last_d   = winner;
          to_cnt_d = '0;
        end
        if (winner == CLEAR) clr_addr_d = '0;
      end
      OWN_A, OWN_B: begin
        if (own_valid) begin
          ctrl_en_d   = own_en;
          ctrl_wr_d   = 4'hF;
          ctrl_addr_d = own_addr;
          ctrl_wdat_d = own_wdat;
          to_cnt_d    = '0;
          if (!own_lock) state_d = IDLE;
        end else if (!own_lock) begin
          state_d = IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          // Lock held with no traffic for too long: force the bus free.
          state_d  = IDLE;
          terr_d   = 1'b1;
          to_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: begin
        ctrl_en_d   = 9'h1FF;
        ctrl_wr_d   = 4'hF;
        ctrl_addr_d = 16'(clr_addr_q);
        ctrl_wdat_d = CLEAR_VALUE;
        if (clr_addr_q == CLR_LAST) state_d = IDLE;
        else                        clr_addr_d = clr_addr_q + 1'b1;
      end
    endcase
    a_ready_d = (state_d == OWN_A);
    b_ready_d = (state_d == OWN_B);
    grant_d   = state_d;
  end

`ifdef PANEL_ARB_CLEAR_EN
  logic clr_pend_q, clr_pend_d;
  logic busy_q, busy_d;

  // Hold a clear request until the arbiter hands the bus to the clear engine;
  // busy stays up through the cycle that shows the last clear word.
  always_comb begin
    clr_pend_d = clr_pend_q;
    if (clear_start && !busy_q) clr_pend_d = 1'b1;
    if ((state_q == IDLE) && (winner == CLEAR)) clr_pend_d = 1'b0;
    busy_d = clr_pend_d || (state_d == CLEAR) || (state_q == CLEAR);
  end

  // Clear request flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      clr_pend_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      clr_pend_q <= clr_pend_d;
      busy_q     <= busy_d;
    end
  end

  assign clr_req    = clr_pend_q;
  assign clear_busy = busy_q;
`else
  assign clr_req = 1'b0;
`endif

  // Arbiter state and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= RESET_LAST;
      to_cnt_q    <= '0;
      clr_addr_q  <= '0;
      a_ready_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      grant_q     <= 2'd0;
      terr_q      <= 1'b0;
      ctrl_en_q   <= 9'h000;
      ctrl_wr_q   <= 4'h0;
      ctrl_addr_q <= 16'h0000;
      ctrl_wdat_q <= 24'h000000;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      to_cnt_q    <= to_cnt_d;
      clr_addr_q  <= clr_addr_d;
      a_ready_q   <= a_ready_d;
      b_ready_q   <= b_ready_d;
      grant_q     <= grant_d;
      terr_q      <= terr_d;
      ctrl_en_q   <= ctrl_en_d;
      ctrl_wr_q   <= ctrl_wr_d;
      ctrl_addr_q <= ctrl_addr_d;
      ctrl_wdat_q <= ctrl_wdat_d;
    end
  end

  assign a_ready     = a_ready_q;
  assign b_ready     = b_ready_q;
  assign grant       = grant_q;
  assign timeout_err = terr_q;
  assign ctrl_en     = ctrl_en_q;
  assign ctrl_wr     = ctrl_wr_q;
  assign ctrl_addr   = ctrl_addr_q;
  assign ctrl_wdat   = ctrl_wdat_q;

endmodule
`default_nettype wire

// File: tb/tb_panel_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_panel_bus_arbiter                                          |
// | Desc     : Directed vector bench for panel_bus_arbiter (A/B arbitration, |
// |            bursts, lock timeout, reset; clear engine when                |
// |            PANEL_ARB_CLEAR_EN is defined).                               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_panel_bus_arbiter;

  localparam int unsigned CLEAR_WORDS  = 8;
  localparam logic [23:0] CLEAR_VALUE  = 24'h5A5A5A;
  localparam int unsigned LOCK_TIMEOUT = 16;
  localparam logic [8:0]  A_EN = 9'h1FF;
  localparam logic [8:0]  B_EN = 9'h0A5;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_valid, a_ready, a_lock;
  logic [8:0]  a_en;
  logic [15:0] a_addr;
  logic [23:0] a_wdat;
  logic        b_valid, b_ready, b_lock;
  logic [8:0]  b_en;
  logic [15:0] b_addr;
  logic [23:0] b_wdat;
  logic        clear_start;
  logic        clear_busy;
  logic [8:0]  ctrl_en;
  logic [3:0]  ctrl_wr;
  logic [15:0] ctrl_addr;
  logic [23:0] ctrl_wdat;
  logic [1:0]  grant;
  logic        timeout_err;

  panel_bus_arbiter #(
    .CLEAR_WORDS (CLEAR_WORDS),
    .CLEAR_VALUE (CLEAR_VALUE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_lock     (a_lock),
    .a_en       (a_en),
    .a_addr     (a_addr),
    .a_wdat     (a_wdat),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_lock     (b_lock),
    .b_en       (b_en),
    .b_addr     (b_addr),
    .b_wdat     (b_wdat),
`ifdef PANEL_ARB_CLEAR_EN
    .clear_start(clear_start),
    .clear_busy (clear_busy),
`endif
    .ctrl_en    (ctrl_en),
    .ctrl_wr    (ctrl_wr),
    .ctrl_addr  (ctrl_addr),
    .ctrl_wdat  (ctrl_wdat),
    .grant      (grant),
    .timeout_err(timeout_err)
  );

`ifndef PANEL_ARB_CLEAR_EN
  assign clear_busy = 1'b0;
`endif

  always #5 clock = ~clock;

  // One cycle of stimulus: inputs for this cycle, outputs expected in it.
  typedef struct {
    logic        av, al;
    logic [15:0] aa;
    logic [23:0] ad;
    logic        bv, bl;
    logic [15:0] ba;
    logic [23:0] bd;
    logic        ar, br;
    logic [1:0]  gnt;
    logic        terr;
    logic [8:0]  cen;
    logic [15:0] caddr;
    logic [23:0] cdat;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic [15:0] aa, ba, na, pb;
  logic [23:0] ad, bd, nd, pdb;
  logic        nv;
  logic [63:0] act, exp_v;

  function automatic vec_t row(
    input logic av, al, input logic [15:0] aa_i, input logic [23:0] ad_i,
    input logic bv, bl, input logic [15:0] ba_i, input logic [23:0] bd_i,
    input logic ar, br, input logic [1:0] gnt, input logic terr,
    input logic [8:0] cen, input logic [15:0] caddr, input logic [23:0] cdat);
    vec_t v;
    v.av = av; v.al = al; v.aa = aa_i; v.ad = ad_i;
    v.bv = bv; v.bl = bl; v.ba = ba_i; v.bd = bd_i;
    v.ar = ar; v.br = br; v.gnt = gnt; v.terr = terr;
    v.cen = cen; v.caddr = caddr; v.cdat = cdat;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  initial begin
    reset = 1'b1;
    a_valid = 1'b0; a_lock = 1'b0; a_en = A_EN; a_addr = '0; a_wdat = '0;
    b_valid = 1'b0; b_lock = 1'b0; b_en = B_EN; b_addr = '0; b_wdat = '0;
    clear_start = 1'b0;

    // ---- vector table ----
    // Both ports always valid, 4 unlocked beats each: A,B,A,B,... from reset.
    pb = '0; pdb = '0;
    for (int k = 0; k < 4; k++) begin
      aa = 16'(16'h0100 + k);
      ad = 24'(24'hA00000 + k);
      ba = (k == 3) ? 16'hFFFF : 16'(16'h0200 + k);
      bd = 24'(24'hB00000 + k);
      nv = (k < 3);
      na = nv ? 16'(16'h0101 + k) : 16'h0000;
      nd = nv ? 24'(24'hA00001 + k) : 24'h000000;
      tbl.push_back(row(Y, N, aa, ad, Y, N, ba, bd, N, N, 2'd0, N,
                        (k == 0) ? 9'h000 : B_EN, pb, pdb));
      tbl.push_back(row(Y, N, aa, ad, Y, N, ba, bd, Y, N, 2'd1, N, '0, '0, '0));
      tbl.push_back(row(nv, N, na, nd, Y, N, ba, bd, N, N, 2'd0, N, A_EN, aa, ad));
      tbl.push_back(row(nv, N, na, nd, Y, N, ba, bd, N, Y, 2'd2, N, '0, '0, '0));
      pb = ba; pdb = bd;
    end
    tbl.push_back(row(N, N, '0, '0, N, N, '0, '0, N, N, 2'd0, N, B_EN, pb, pdb));
    // Single unlocked A beat.
    tbl.push_back(row(Y, N, 16'h0010, 24'h123456, N, N, '0, '0, N, N, 2'd0, N, '0, '0, '0));
    tbl.push_back(row(Y, N, 16'h0010, 24'h123456, N, N, '0, '0, Y, N, 2'd1, N, '0, '0, '0));
    tbl.push_back(row(N, N, '0, '0, N, N, '0, '0, N, N, 2'd0, N, A_EN, 16'h0010, 24'h123456));
    // Locked 8-beat A burst while B requests throughout.
    tbl.push_back(row(Y, Y, 16'h0300, 24'h300000, N, N, '0, '0, N, N, 2'd0, N, '0, '0, '0));
    for (int k = 0; k < 8; k++) begin
      tbl.push_back(row(Y, (k < 7), 16'(16'h0300 + k), 24'(24'h300000 + k),
                        Y, N, 16'h0400, 24'hC0FFEE, Y, N, 2'd1, N,
                        (k == 0) ? 9'h000 : A_EN,
                        (k == 0) ? 16'h0000 : 16'(16'h02FF + k),
                        (k == 0) ? 24'h000000 : 24'(24'h2FFFFF + k)));
    end
    tbl.push_back(row(N, N, '0, '0, Y, N, 16'h0400, 24'hC0FFEE, N, N, 2'd0, N, A_EN, 16'h0307, 24'h300007));
    tbl.push_back(row(N, N, '0, '0, Y, N, 16'h0400, 24'hC0FFEE, N, Y, 2'd2, N, '0, '0, '0));
    tbl.push_back(row(N, N, '0, '0, N, N, '0, '0, N, N, 2'd0, N, B_EN, 16'h0400, 24'hC0FFEE));
    // A takes one beat, then holds the lock idle until the timeout fires.
    tbl.push_back(row(Y, Y, 16'h0500, 24'h555555, N, N, '0, '0, N, N, 2'd0, N, '0, '0, '0));
    tbl.push_back(row(Y, Y, 16'h0500, 24'h555555, N, N, '0, '0, Y, N, 2'd1, N, '0, '0, '0));
    tbl.push_back(row(N, Y, '0, '0, Y, N, 16'h0600, 24'h666666, Y, N, 2'd1, N, A_EN, 16'h0500, 24'h555555));
    for (int k = 1; k < 16; k++)
      tbl.push_back(row(N, Y, '0, '0, Y, N, 16'h0600, 24'h666666, Y, N, 2'd1, N, '0, '0, '0));
    tbl.push_back(row(N, N, '0, '0, Y, N, 16'h0600, 24'h666666, N, N, 2'd0, Y, '0, '0, '0));
    tbl.push_back(row(N, N, '0, '0, Y, N, 16'h0600, 24'h666666, N, Y, 2'd2, N, '0, '0, '0));
    tbl.push_back(row(N, N, '0, '0, N, N, '0, '0, N, N, 2'd0, N, B_EN, 16'h0600, 24'h666666));
    tbl.push_back(row(N, N, '0, '0, N, N, '0, '0, N, N, 2'd0, N, '0, '0, '0));

    // ---- reset state ----
    cyc(); cyc(); cyc();
    check("reset_outputs", {a_ready, b_ready, grant, timeout_err, ctrl_en, ctrl_wr,
                            ctrl_addr, ctrl_wdat}, 64'h0);
    check("reset_busy", {63'h0, clear_busy}, 64'h0);
    reset = 1'b0;

    // ---- apply table ----
    foreach (tbl[i]) begin
      exp_v = {6'h0, tbl[i].ar, tbl[i].br, tbl[i].gnt, tbl[i].terr, tbl[i].cen,
               (tbl[i].cen != 9'h000) ? 4'hF : 4'h0,
               (tbl[i].cen != 9'h000) ? tbl[i].caddr : 16'h0000,
               (tbl[i].cen != 9'h000) ? tbl[i].cdat  : 24'h000000};
      act   = {6'h0, a_ready, b_ready, grant, timeout_err, ctrl_en, ctrl_wr,
               (tbl[i].cen != 9'h000) ? ctrl_addr : 16'h0000,
               (tbl[i].cen != 9'h000) ? ctrl_wdat : 24'h000000};
      check($sformatf("row%0d", i), act, exp_v);
      a_valid = tbl[i].av; a_lock = tbl[i].al; a_addr = tbl[i].aa; a_wdat = tbl[i].ad;
      b_valid = tbl[i].bv; b_lock = tbl[i].bl; b_addr = tbl[i].ba; b_wdat = tbl[i].bd;
      cyc();
    end

    // ---- reset mid-burst, then both request: A wins ----
    a_valid = 1'b1; a_lock = 1'b1; a_addr = 16'h0900; a_wdat = 24'h999999;
    cyc();
    check("burst_grant", {62'h0, grant}, 64'd1);
    cyc();
    check("burst_write", {ctrl_en, ctrl_addr}, {A_EN, 16'h0900});
    reset = 1'b1;
    cyc();
    check("midburst_reset", {a_ready, b_ready, grant, ctrl_en, ctrl_wr}, 64'h0);
    reset = 1'b0;
    a_lock = 1'b0; a_addr = 16'h0A00; a_wdat = 24'hAAAAAA;
    b_valid = 1'b1; b_addr = 16'h0B00; b_wdat = 24'hBBBBBB;
    cyc();
    check("both_req_a_wins", {a_ready, b_ready, grant}, {1'b1, 1'b0, 2'd1});
    cyc();
    a_valid = 1'b0; b_valid = 1'b0;
    check("post_reset_beat", {ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat},
          {A_EN, 4'hF, 16'h0A00, 24'hAAAAAA});
    cyc(); cyc();

`ifdef PANEL_ARB_CLEAR_EN
    // ---- clear requested during an A burst ----
    a_valid = 1'b1; a_lock = 1'b1; a_addr = 16'h0700; a_wdat = 24'h700000;
    cyc();
    check("clr_burst_grant", {62'h0, grant}, 64'd1);
    clear_start = 1'b1;
    cyc();
    clear_start = 1'b0;
    check("clr_pending_busy", {grant, clear_busy}, {2'd1, 1'b1});
    a_lock = 1'b0; a_addr = 16'h0701; a_wdat = 24'h700001;
    cyc();
    a_valid = 1'b0;
    check("clr_waits_burst", {grant, ctrl_en, ctrl_addr}, {2'd0, A_EN, 16'h0701});
    cyc();
    check("clr_grant", {grant, clear_busy}, {2'd3, 1'b1});
    for (int k = 0; k < 8; k++) begin
      cyc();
      check($sformatf("clr_word%0d", k),
            {clear_busy, ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat},
            {1'b1, 9'h1FF, 4'hF, 16'(k), CLEAR_VALUE});
      clear_start = (k == 2);
    end
    cyc();
    check("clr_done", {clear_busy, grant, ctrl_en, ctrl_wr}, 64'h0);
    cyc();
    check("clr_no_repeat", {clear_busy, grant}, 64'h0);

    // ---- reset during a clear at word 3 ----
    clear_start = 1'b1;
    cyc();
    clear_start = 1'b0;
    check("clr2_busy", {63'h0, clear_busy}, 64'd1);
    cyc();
    for (int k = 0; k < 4; k++) cyc();
    check("clr2_at_word3", {ctrl_wr, ctrl_addr}, {4'hF, 16'h0003});
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("clr2_reset", {ctrl_en, ctrl_wr, grant, clear_busy}, 64'h0);
    a_valid = 1'b1; a_addr = 16'h0C00; a_wdat = 24'hCCCCCC;
    cyc();
    check("clr2_a_grant", {a_ready, grant}, {1'b1, 2'd1});
    a_valid = 1'b0;
    cyc();
    check("clr2_a_write", {clear_busy, ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat},
          {1'b0, A_EN, 4'hF, 16'h0C00, 24'hCCCCCC});
    cyc();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
